uart_rx_os: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_os.sv | 141 ++++++++++++++
 tb/tb_uart_rx_os.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART: FSM states, sampling window
// and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    localparam int         OVERSAMPLE   = 16;
    localparam int         DATA_BITS    = 8;
    localparam logic [3:0] SAMPLE_FIRST = 4'd7;
    localparam logic [3:0] SAMPLE_LAST  = 4'd9;
    localparam logic [3:0] OS_LAST      = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

    // votes holds the ones seen at the first two sample points; s is the third.
    function automatic logic majority(input logic [1:0] votes, input logic s);
        return (({1'b0, votes} + {2'b00, s}) >= 3'd2);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running fractional baud tick: one-clock pulse at BAUD*OVERSAMPLE Hz.
module uart_baud_tick #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [32:0] INC = 33'(BAUD * OVERSAMPLE);
    localparam logic [32:0] LIM = 33'(CLK_FREQ);

    logic [31:0] acc_q, acc_d;
    logic        tick_q, tick_d;
    logic [32:0] sum;

    always_comb begin
        sum    = {1'b0, acc_q} + INC;
        acc_d  = sum[31:0];
        tick_d = 1'b0;
        if (sum >= LIM) begin
            acc_d  = 32'(sum - LIM);
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling and a 3-sample majority vote per bit.
// ready is a one-clock pulse with data valid in that cycle; there is no back-pressure.
module uart_rx_os #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err,
    output logic       busy
);
    import uart_pkg::*;

    logic       tick;
    logic [1:0] sync_q;
    logic       rx_s;
    state_e     state_q, state_d;
    logic [3:0] os_cnt_q, os_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [1:0] votes_q, votes_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       ferr_q, ferr_d;
    logic       maj, mid, wrap, counting;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign rx_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        votes_d   = votes_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
        maj       = majority(votes_q, rx_s);
        mid       = (os_cnt_q == SAMPLE_LAST);
        wrap      = (os_cnt_q == OS_LAST);
        counting  = tick && (state_q == START || state_q == DATA || state_q == STOP);

        // Votes accumulate over the sample window and restart at each bit boundary.
        if (counting) begin
            os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q >= SAMPLE_FIRST && os_cnt_q < SAMPLE_LAST)
                votes_d = votes_q + {1'b0, rx_s};
            if (wrap)
                votes_d = 2'd0;
        end

        case (state_q)
            IDLE: begin
                if (tick && !rx_s) begin
                    os_cnt_d = 4'd0;
                    votes_d  = 2'd0;
                    state_d  = START;
                end
            end
            START: begin
                if (counting && mid && maj) begin
                    state_d = IDLE;
                end else if (counting && wrap) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (counting && mid)
                    shreg_d = {maj, shreg_q[7:1]};
                if (counting && wrap) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT)
                        state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit gives half a bit of resync margin.
                if (counting && mid) begin
                    if (maj) begin
                        data_d  = shreg_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            votes_q   <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            votes_q   <= votes_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data      = data_q;
    assign ready     = ready_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven at the pin, a queue of
// expected outcomes (byte or framing error) is checked every clock.
module tb_uart_rx_os;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       busy;

    uart_rx_os #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .ready    (ready),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Expected events: bit 8 set = framing error, else bits 7:0 = received byte.
    logic [8:0]  exp_q[$];
    logic [7:0]  model_data = 8'h00;
    logic        ready_prev = 1'b0;
    int          n_total    = 0;
    int          n_pass     = 0;
    int          ready_cnt  = 0;
    int          ferr_cnt   = 0;
    longint      cyc        = 0;
    longint      ready_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every cycle out of reset, events must match the queue and data must hold.
    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        if (!rst) begin
            model_data = 8'h00;
            chk("rst_data", 32'(data), 32'h0);
            chk("rst_ready", 32'(ready), 32'h0);
            chk("rst_frame_err", 32'(frame_err), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end else begin
            if (ready || frame_err) begin
                chk("ready_ferr_exclusive", 32'(ready & frame_err), 32'h0);
                if (ready) begin
                    chk("ready_width", 32'(ready_prev), 32'h0);
                    ready_cnt++;
                    ready_cyc.push_back(cyc);
                end
                if (frame_err) ferr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'({ready, frame_err}), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'(frame_err), 32'(e[8]));
                    if (ready) model_data = e[7:0];
                end
            end
            chk("data", 32'(data), 32'(model_data));
        end
        ready_prev = ready;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
        exp_q.push_back(stop_bit ? {1'b0, b} : 9'h100);
        rx = 1'b0;
        step(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(per);
        end
        rx = stop_bit;
        step(per);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            step(1);
            budget--;
        end
        chk(name, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        step(4);
        rst = 1'b1;
        step(10);
        chk("idle_busy", 32'(busy), 32'h0);

        // Back-to-back frames: ready spacing equals one 10-bit frame.
        send_frame(8'h55, BIT_CLKS, 1'b1);
        send_frame(8'hA3, BIT_CLKS, 1'b1);
        drain("drain_b2b");
        chk("b2b_data", 32'(data), 32'hA3);
        chk("b2b_ready_cnt", 32'(ready_cnt), 32'd2);
        chk("b2b_spacing", 32'(ready_cyc[1] - ready_cyc[0]), 32'd320);
        chk("b2b_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // ASCII "1f "
        send_frame(8'h31, BIT_CLKS, 1'b1);
        send_frame(8'h66, BIT_CLKS, 1'b1);
        send_frame(8'h20, BIT_CLKS, 1'b1);
        drain("drain_ascii");
        chk("ascii_data", 32'(data), 32'h20);
        chk("ascii_ready_cnt", 32'(ready_cnt), 32'd5);

        // 10-clock glitch: false start, no output, busy back low.
        step(20);
        rx = 1'b0;
        step(10);
        chk("glitch_busy_high", 32'(busy), 32'h1);
        rx = 1'b1;
        step(40);
        chk("glitch_busy_low", 32'(busy), 32'h0);
        chk("glitch_ready_cnt", 32'(ready_cnt), 32'd5);
        chk("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Bad stop bit keeps old data; next good frame recovers.
        send_frame(8'h7E, BIT_CLKS, 1'b0);
        step(20);
        drain("drain_bad_stop");
        chk("bad_stop_data_held", 32'(data), 32'h20);
        chk("bad_stop_ferr_cnt", 32'(ferr_cnt), 32'd1);
        chk("bad_stop_busy", 32'(busy), 32'h0);
        send_frame(8'h41, BIT_CLKS, 1'b1);
        drain("drain_after_bad");
        chk("after_bad_data", 32'(data), 32'h41);

        // Line break: exactly one framing error.
        exp_q.push_back(9'h100);
        rx = 1'b0;
        step(2000);
        chk("break_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        step(20);
        drain("drain_break");
        chk("break_ferr_cnt", 32'(ferr_cnt), 32'd2);
        chk("break_busy_low", 32'(busy), 32'h0);
        send_frame(8'hC3, BIT_CLKS, 1'b1);
        drain("drain_after_break");
        chk("after_break_data", 32'(data), 32'hC3);

        // Reset halfway through bit 4 of 0xFF discards the partial byte.
        rx = 1'b0;
        step(BIT_CLKS);
        rx = 1'b1;
        step(4 * BIT_CLKS + BIT_CLKS / 2);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        step(3);
        chk("mid_rst_data", 32'(data), 32'h00);
        chk("mid_rst_ready_cnt", 32'(ready_cnt), 32'd7);
        rst = 1'b1;
        step(20);
        send_frame(8'h12, BIT_CLKS, 1'b1);
        drain("drain_after_rst");
        chk("after_rst_data", 32'(data), 32'h12);

        // -3% bit period.
        send_frame(8'h5A, BIT_CLKS - 1, 1'b1);
        step(10);
        drain("drain_slow");
        chk("slow_data", 32'(data), 32'h5A);
        chk("final_ready_cnt", 32'(ready_cnt), 32'd9);
        chk("final_ferr_cnt", 32'(ferr_cnt), 32'd2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
